// File: rtl/lenet5_run_sequencer.sv
// Run sequencer for the lenet5 ap_ctrl handshake: issues one transaction
// per image, measures latency and total run time, and guards each image.
module lenet5_run_sequencer #(
  parameter int IMG_W          = 16,
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cfg_start,
  input  logic [IMG_W-1:0] cfg_num_images,
  output logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  output logic             ap_continue,
  output logic             busy,
  output logic [IMG_W-1:0] img_index,
  output logic [CNT_W-1:0] last_latency,
  output logic [CNT_W-1:0] total_cycles,
  output logic             finish,
  output logic             timeout_err
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_DONE,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  state_t           state;
  state_t           state_nx;
  logic [IMG_W-1:0] num_q;
  logic [IMG_W-1:0] img_q;
  logic [CNT_W-1:0] lat_q;
  logic [CNT_W-1:0] last_q;
  logic [CNT_W-1:0] total_q;
  logic             tmo_q;

  logic is_busy;
  logic launched;
  logic accept;
  logic complete;
  logic expire;
  logic last_img;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // lat_q == 0 marks the one-cycle gap before the next ap_start
  assign is_busy  = (state == START) || (state == WAIT_DONE);
  assign launched = (lat_q != '0);
  assign accept   = cfg_start && !is_busy;
  assign complete = is_busy && launched && ap_done;
  assign expire   = is_busy && launched && !ap_done
                    && (lat_q == LIMIT);
  assign last_img = ((img_q + IMG_W'(1)) == num_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: begin
        if (accept) begin
          state_nx = (cfg_num_images == '0) ? DONE : START;
        end
      end
      START: begin
        if (complete) begin
          state_nx = last_img ? DONE : START;
        end else if (expire) begin
          state_nx = DONE;
        end else if (launched && ap_ready) begin
          state_nx = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (complete) begin
          state_nx = last_img ? DONE : START;
        end else if (expire) begin
          state_nx = DONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy        = is_busy;
    ap_start    = (state == START) && launched;
    ap_continue = ap_done && is_busy;
    finish      = (state == DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      num_q   <= '0;
      img_q   <= '0;
      lat_q   <= '0;
      last_q  <= '0;
      total_q <= '0;
      tmo_q   <= 1'b0;
    end else if (accept) begin
      num_q   <= cfg_num_images;
      img_q   <= '0;
      total_q <= '0;
      last_q  <= '0;
      tmo_q   <= 1'b0;
      lat_q   <= (cfg_num_images == '0) ? '0 : CNT_W'(1);
    end else if (is_busy) begin
      total_q <= sat_inc(total_q);
      if (complete) begin
        last_q <= lat_q;
        img_q  <= img_q + IMG_W'(1);
        lat_q  <= '0;
      end else if (expire) begin
        tmo_q <= 1'b1;
        lat_q <= '0;
      end else begin
        lat_q <= sat_inc(lat_q);
      end
    end
  end

  assign img_index    = img_q;
  assign last_latency = last_q;
  assign total_cycles = total_q;
  assign timeout_err  = tmo_q;

endmodule

// File: tb/tb_lenet5_run_sequencer.sv
// Scoreboard bench for lenet5_run_sequencer: a scripted ap_ctrl responder,
// a reference model of each run and a decoupled output monitor.
module tb_lenet5_run_sequencer;

  localparam int TO = 50;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_start = 1'b0;
  logic [15:0] cfg_num_images = '0;
  logic        ap_ready = 1'b0;
  logic        ap_done = 1'b0;
  logic        ap_start;
  logic        ap_continue;
  logic        busy;
  logic [15:0] img_index;
  logic [31:0] last_latency;
  logic [31:0] total_cycles;
  logic        finish;
  logic        timeout_err;

  lenet5_run_sequencer #(
    .IMG_W(16),
    .CNT_W(32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .cfg_start(cfg_start),
    .cfg_num_images(cfg_num_images),
    .ap_start(ap_start),
    .ap_ready(ap_ready),
    .ap_done(ap_done),
    .ap_continue(ap_continue),
    .busy(busy),
    .img_index(img_index),
    .last_latency(last_latency),
    .total_cycles(total_cycles),
    .finish(finish),
    .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    int lat;
    int width;
    int idx;
  } img_t;

  typedef struct {
    int imgs;
    int total;
    int tmo;
    int last;
  } run_t;

  img_t exp_img[$];
  run_t exp_run[$];
  int   emu_r[$];
  int   emu_d[$];
  int   plan_r[$];
  int   plan_d[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  // responder: ready at cycle r, done at cycle d of each transaction
  bit emu_active = 0;
  int emu_k = 0;
  int cur_r = 0;
  int cur_d = 0;
  bit real_done = 0;
  bit stray = 0;

  always @(negedge clock) begin
    if (reset || !busy) emu_active = 0;
    if (!emu_active && ap_start && !reset) begin
      emu_active = 1;
      emu_k = 1;
      if (emu_d.size() > 0) begin
        cur_r = emu_r.pop_front();
        cur_d = emu_d.pop_front();
      end else begin
        cur_r = 1;
        cur_d = 1;
      end
    end else if (emu_active) begin
      emu_k++;
    end
    #1;
    real_done = emu_active && cur_d != 0 && emu_k == cur_d;
    ap_ready  = emu_active && emu_k == cur_r;
    ap_done   = real_done || (stray && !emu_active);
    if (real_done) emu_active = 0;
  end

  bit mon_active = 0;
  int mlat = 0;
  int mwidth = 0;
  bit pend = 0;
  int pend_lat = 0;
  int pend_idx = 0;
  bit prev_finish = 0;

  always @(negedge clock) begin
    img_t e;
    run_t r;
    #2;
    if (reset) begin
      mon_active = 0;
      pend = 0;
      prev_finish = 0;
    end else begin
      if (pend) begin
        chk("last_latency", last_latency, pend_lat);
        chk("img_index_step", img_index, pend_idx);
        pend = 0;
      end
      chk("ap_continue", ap_continue, real_done);
      if (finish && !prev_finish) begin
        if (exp_run.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_finish: got 1, want 0");
        end else begin
          r = exp_run.pop_front();
          chk("run_img_index", img_index, r.imgs);
          chk("run_total_cycles", total_cycles, r.total);
          chk("run_timeout_err", timeout_err, r.tmo);
          chk("run_last_latency", last_latency, r.last);
          chk("run_ap_start", ap_start, 0);
          if (r.tmo != 0) chk("watchdog_count", mlat, TO);
        end
        mon_active = 0;
      end
      prev_finish = finish;
      if (ap_start && !mon_active) begin
        mon_active = 1;
        mlat = 1;
        mwidth = 1;
      end else if (mon_active) begin
        mlat++;
        if (ap_start) mwidth++;
      end
      if (ap_continue && mon_active) begin
        if (exp_img.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got 1, want 0");
        end else begin
          e = exp_img.pop_front();
          chk("img_latency", mlat, e.lat);
          chk("ap_start_width", mwidth, e.width);
          pend = 1;
          pend_lat = e.lat;
          pend_idx = e.idx;
        end
        mon_active = 0;
      end
    end
  end

  // model: image i takes d cycles (0 = hangs), one gap between images
  task automatic start_run(int n);
    run_t e;
    int total = 0;
    int done = 0;
    int r;
    int d;
    e = '{0, 0, 0, 0};
    for (int i = 0; i < n; i++) begin
      if (e.tmo == 0) begin
        r = plan_r[i];
        d = plan_d[i];
        emu_r.push_back(r);
        emu_d.push_back(d);
        if (d == 0 || d > TO) begin
          total += TO;
          e.tmo = 1;
        end else begin
          total += d;
          done++;
          e.last = d;
          exp_img.push_back('{d, (r != 0 && r < d) ? r : d, done});
          if (i < n - 1) total += 1;
        end
      end
    end
    e.imgs = done;
    e.total = total;
    exp_run.push_back(e);
    @(negedge clock);
    #1;
    cfg_num_images = 16'(n);
    cfg_start = 1'b1;
    @(negedge clock);
    #1;
    cfg_start = 1'b0;
  endtask

  task automatic wait_finish();
    int cyc = 0;
    while (!finish && cyc < 5000) begin
      @(negedge clock);
      #3;
      cyc++;
    end
    if (!finish) begin
      checks++;
      errors++;
      $display("FAIL finish_wait: got 0, want 1");
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic plan(int n, int r, int d);
    plan_r.delete();
    plan_d.delete();
    for (int i = 0; i < n; i++) begin
      plan_r.push_back(r);
      plan_d.push_back(d);
    end
  endtask

  initial begin
    int n;
    int d;
    int idx;
    int cyc;
    repeat (3) @(negedge clock);
    chk("rst_ap_start", ap_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_finish", finish, 0);
    chk("rst_img_index", img_index, 0);
    chk("rst_total", total_cycles, 0);
    #3 reset = 1'b0;

    plan(0, 0, 0);
    start_run(0);
    chk("n0_finish_next", finish, 1);
    chk("n0_ap_start", ap_start, 0);
    wait_finish();

    plan(3, 1, 10);
    start_run(3);
    wait_finish();

    plan(2, 4, 4);
    start_run(2);
    wait_finish();

    plan(5, 2, 5);
    plan_d[0] = 12;
    plan_d[1] = 0;
    start_run(5);
    wait_finish();
    chk("tmo_ap_start", ap_start, 0);

    plan(1, 1, TO);
    start_run(1);
    wait_finish();

    plan(2, 3, TO + 1);
    start_run(2);
    wait_finish();

    plan(2, 0, 7);
    start_run(2);
    wait_finish();

    idx = img_index;
    #1 stray = 1'b1;
    @(negedge clock);
    #3 stray = 1'b0;
    @(negedge clock);
    #3;
    chk("stray_img_index", img_index, idx);
    chk("stray_finish", finish, 1);

    plan(2, 2, 20);
    start_run(2);
    repeat (5) @(negedge clock);
    #1;
    cfg_num_images = 16'd7;
    cfg_start = 1'b1;
    @(negedge clock);
    #1 cfg_start = 1'b0;
    wait_finish();
    plan(1, 1, 6);
    start_run(1);
    chk("restart_finish", finish, 0);
    chk("restart_busy", busy, 1);
    wait_finish();

    plan(4, 3, 30);
    start_run(4);
    cyc = 0;
    while (img_index != 1 && cyc < 500) begin
      @(negedge clock);
      cyc++;
    end
    chk("mid_reach_img2", img_index, 1);
    repeat (8) @(negedge clock);
    #4 reset = 1'b1;
    #1;
    chk("arst_ap_start", ap_start, 0);
    chk("arst_busy", busy, 0);
    chk("arst_img_index", img_index, 0);
    chk("arst_total", total_cycles, 0);
    chk("arst_last", last_latency, 0);
    chk("arst_finish", finish, 0);
    exp_img.delete();
    exp_run.delete();
    emu_r.delete();
    emu_d.delete();
    repeat (2) @(negedge clock);
    #3 reset = 1'b0;
    plan(1, 1, 5);
    start_run(1);
    wait_finish();

    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(4, 1);
      plan_r.delete();
      plan_d.delete();
      for (int i = 0; i < n; i++) begin
        d = $urandom_range(45, 1);
        plan_d.push_back(d);
        plan_r.push_back($urandom_range(d + 2, 0));
      end
      start_run(n);
      wait_finish();
    end

    chk("queue_img_empty", exp_img.size(), 0);
    chk("queue_run_empty", exp_run.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
